// File: rtl/fetch_pkg.sv
// Shared widths, NOP encoding and fetch FSM state type for the IF stage.
package fetch_pkg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats capture.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;

  always_comb begin
    pc_d    = pc_i;
    inst_d  = inst_i;
    valid_d = 1'b1;
    if (bubble_i) begin
      pc_d    = '0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (hold_i) begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// PC generation, RUN/DONE fetch FSM and IF/ID register for the RV64 pipeline.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects set a sticky error and halt fetch.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_RESET       = 64'h0,
  parameter int unsigned     INST_MEM_BYTES = 112
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   inst_addr,
  input  logic [INST_W-1:0] inst_in,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [INST_W-1:0] ifid_inst,
  output logic              ifid_valid,
  output logic              fetch_done,
  output logic              misalign_err
);

  localparam logic [PC_W:0] MEM_LIMIT = (PC_W + 1)'(INST_MEM_BYTES);

  // One extra bit so pc + 3 cannot wrap back into range.
  function automatic logic in_range(input logic [PC_W-1:0] addr);
    return ({1'b0, addr} + (PC_W + 1)'(3)) < MEM_LIMIT;
  endfunction

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pc_ok;
  logic            fetch_idle;
  logic            redirect_bad;
  logic            ifid_hold;
  logic            ifid_bubble;

  assign pc_ok      = in_range(pc_q);
  assign fetch_idle = (state_q == DONE) || !pc_ok;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign misalign_d   = misalign_q | redirect_bad;

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  assign redirect_bad = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    if (redirect_valid) begin
      ifid_bubble = 1'b1;
      if (redirect_bad) begin
        state_d = DONE;
      end else begin
        pc_d = redirect_pc;
        if (in_range(redirect_pc)) state_d = RUN;
      end
    end else begin
      // An out-of-range pc in RUN is never fetched; DONE follows one edge later.
      if (state_q == RUN && !pc_ok) state_d = DONE;
      if (stall)           ifid_hold   = 1'b1;
      else if (fetch_idle) ifid_bubble = 1'b1;
      else                 pc_d        = pc_q + PC_W'(4);
      if (flush) ifid_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign inst_addr  = pc_q;
  assign fetch_done = (state_q == DONE);

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (ifid_hold),
    .bubble_i (ifid_bubble),
    .pc_i     (pc_q),
    .inst_i   (inst_in),
    .pc_o     (ifid_pc),
    .inst_o   (ifid_inst),
    .valid_o  (ifid_valid)
  );

endmodule
